// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle main control FSM:
// opcodes, state encodings, ALU-op classes and the control-word layout.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEZ   = 6'b011000;
  localparam logic [5:0] OP_BGEZ  = 6'b011001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JM    = 6'b010010;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_JM_READ   = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_I_EXEC    = 4'd9,
    ST_I_WB      = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_MDR    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       br_sel;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Dispatch target out of DECODE; undefined opcodes fall back to FETCH.
  function automatic state_e decode_target(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:            nxt = ST_R_EXEC;
      OP_LW, OP_SW, OP_JM: nxt = ST_MEM_ADDR;
      OP_ANDI:             nxt = ST_I_EXEC;
      OP_BEZ, OP_BGEZ:     nxt = ST_BRANCH;
      OP_J:                nxt = ST_JUMP;
      default:             nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic is_defined_op(input logic [5:0] op);
    return (op inside {OP_RTYPE, OP_LW, OP_SW, OP_JM, OP_ANDI, OP_BEZ, OP_BGEZ, OP_J});
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle datapath: sequences fetch/decode/execute/
// memory/writeback, waits on mem_ready for memory states, drives the ALU-op class.
module multicycle_main_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       br_sel,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE:    state_d = decode_target(opcode);
      ST_MEM_ADDR: begin
        case (opcode)
          OP_LW:   state_d = ST_MEM_READ;
          OP_SW:   state_d = ST_MEM_WRITE;
          OP_JM:   state_d = ST_JM_READ;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_JM_READ:   if (mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_I_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    unique case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC only load on the cycle the read actually completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SH2;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.illegal_op = ~is_defined_op(opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_JM_READ: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.pc_source = PC_SRC_MDR;
        ctrl.pc_write  = mem_ready;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.aluop     = ALUOP_RTYPE;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.aluop     = ALUOP_AND;
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.br_sel        = (opcode == OP_BGEZ);
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  // Reset must silence memory and PC strobes immediately, not at the next edge.
  assign ctrl_gated = rst_n ? ctrl : CTRL_IDLE;

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign br_sel        = ctrl_gated.br_sel;
  assign i_or_d        = ctrl_gated.i_or_d;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign ir_write      = ctrl_gated.ir_write;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign aluop1        = ctrl_gated.aluop[1];
  assign aluop0        = ctrl_gated.aluop[0];
  assign pc_source     = ctrl_gated.pc_source;
  assign illegal_op    = ctrl_gated.illegal_op;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: directed cycle table for the
// corner cases, then randomized instruction streams against an instruction-plan model.
module tb_multicycle_main_control;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_ANDI = 6'b001100;
  localparam logic [5:0] T_BEZ  = 6'b011000;
  localparam logic [5:0] T_BGEZ = 6'b011001;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JM   = 6'b010010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       br_sel;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_source;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    obs_t       exp;
  } vec_t;

  typedef enum {
    K_FETCH, K_DECODE, K_ADDR, K_LOAD, K_LOAD_WB, K_STORE, K_JM_LOAD,
    K_R_EXEC, K_R_WB, K_I_EXEC, K_I_WB, K_BRANCH, K_JUMP
  } step_e;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, br_sel, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic       aluop1, aluop0, illegal_op;

  int n_vec  = 0;
  int n_fail = 0;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .br_sel(br_sel),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop1(aluop1), .aluop0(aluop0), .pc_source(pc_source),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.pc_write = pc_write;     o.pc_write_cond = pc_write_cond;
    o.br_sel = br_sel;         o.i_or_d = i_or_d;
    o.mem_read = mem_read;     o.mem_write = mem_write;
    o.ir_write = ir_write;     o.mem_to_reg = mem_to_reg;
    o.reg_dst = reg_dst;       o.reg_write = reg_write;
    o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
    o.aluop = {aluop1, aluop0}; o.pc_source = pc_source;
    o.illegal_op = illegal_op;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, compare at the falling edge.
  task automatic apply(input string name, input logic r, input logic [5:0] op,
                       input logic rdy, input obs_t exp);
    rst_n = r; opcode = op; mem_ready = rdy;
    @(negedge clk);
    check(name, observe(), exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: per-instruction step plans ----------------
  step_e plan[$];

  task automatic build_plan(input logic [5:0] op);
    plan = {K_FETCH, K_DECODE};
    case (op)
      T_LW:    plan = {plan, K_ADDR, K_LOAD, K_LOAD_WB};
      T_SW:    plan = {plan, K_ADDR, K_STORE};
      T_JM:    plan = {plan, K_ADDR, K_JM_LOAD};
      T_R:     plan = {plan, K_R_EXEC, K_R_WB};
      T_ANDI:  plan = {plan, K_I_EXEC, K_I_WB};
      T_BEZ, T_BGEZ: plan.push_back(K_BRANCH);
      T_J:     plan.push_back(K_JUMP);
      default: ;
    endcase
  endtask

  function automatic logic waits_on_memory(input step_e s);
    return s inside {K_FETCH, K_LOAD, K_STORE, K_JM_LOAD};
  endfunction

  function automatic obs_t expect_step(input step_e s, input logic rdy, input logic [5:0] op);
    obs_t e;
    e = '0;
    case (s)
      K_FETCH:   begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      K_DECODE:  begin
        e.alu_src_b = 2'b11;
        e.illegal_op = !(op inside {T_R, T_LW, T_SW, T_JM, T_ANDI, T_BEZ, T_BGEZ, T_J});
      end
      K_ADDR:    begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      K_LOAD:    begin e.mem_read = 1; e.i_or_d = 1; end
      K_LOAD_WB: begin e.reg_write = 1; e.mem_to_reg = 1; end
      K_STORE:   begin e.mem_write = 1; e.i_or_d = 1; end
      K_JM_LOAD: begin e.mem_read = 1; e.i_or_d = 1; e.pc_source = 2'b11; e.pc_write = rdy; end
      K_R_EXEC:  begin e.alu_src_a = 1; e.aluop = 2'b10; end
      K_R_WB:    begin e.reg_write = 1; e.reg_dst = 1; end
      K_I_EXEC:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluop = 2'b11; end
      K_I_WB:    e.reg_write = 1;
      K_BRANCH:  begin
        e.alu_src_a = 1; e.aluop = 2'b01; e.pc_write_cond = 1;
        e.pc_source = 2'b01; e.br_sel = (op == T_BGEZ);
      end
      K_JUMP:    begin e.pc_write = 1; e.pc_source = 2'b10; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  // ---------------- hand-written expected control words ----------------
  localparam obs_t Z    = '0;
  localparam obs_t F1   = '{pc_write:1'b1, mem_read:1'b1, ir_write:1'b1, alu_src_b:2'b01, default:'0};
  localparam obs_t F0   = '{mem_read:1'b1, alu_src_b:2'b01, default:'0};
  localparam obs_t DEC  = '{alu_src_b:2'b11, default:'0};
  localparam obs_t DILL = '{alu_src_b:2'b11, illegal_op:1'b1, default:'0};
  localparam obs_t MA   = '{alu_src_a:1'b1, alu_src_b:2'b10, default:'0};
  localparam obs_t MRD  = '{mem_read:1'b1, i_or_d:1'b1, default:'0};
  localparam obs_t MWB  = '{reg_write:1'b1, mem_to_reg:1'b1, default:'0};
  localparam obs_t STR  = '{mem_write:1'b1, i_or_d:1'b1, default:'0};
  localparam obs_t JM0  = '{mem_read:1'b1, i_or_d:1'b1, pc_source:2'b11, default:'0};
  localparam obs_t JM1  = '{pc_write:1'b1, mem_read:1'b1, i_or_d:1'b1, pc_source:2'b11, default:'0};
  localparam obs_t RE   = '{alu_src_a:1'b1, aluop:2'b10, default:'0};
  localparam obs_t RW   = '{reg_write:1'b1, reg_dst:1'b1, default:'0};
  localparam obs_t IE   = '{alu_src_a:1'b1, alu_src_b:2'b10, aluop:2'b11, default:'0};
  localparam obs_t IW   = '{reg_write:1'b1, default:'0};
  localparam obs_t BR0  = '{alu_src_a:1'b1, aluop:2'b01, pc_write_cond:1'b1, pc_source:2'b01, default:'0};
  localparam obs_t BR1  = '{alu_src_a:1'b1, aluop:2'b01, pc_write_cond:1'b1, pc_source:2'b01, br_sel:1'b1, default:'0};
  localparam obs_t JP   = '{pc_write:1'b1, pc_source:2'b10, default:'0};

  vec_t tbl[$];

  task automatic add(input string n, input logic r, input logic [5:0] op,
                     input logic rdy, input obs_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] cur_op;
    logic [5:0] drive_op;
    logic       rdy, r;
    obs_t       e;

    rst_n = 1'b0; opcode = '0; mem_ready = 1'b1;
    #1;

    add("reset0", 0, T_LW, 1, Z);
    add("reset1", 0, T_LW, 1, Z);
    add("lw_fetch", 1, T_BAD, 1, F1);
    add("lw_decode", 1, T_LW, 1, DEC);
    add("lw_addr", 1, T_LW, 1, MA);
    add("lw_read", 1, T_LW, 1, MRD);
    add("lw_wb", 1, T_LW, 1, MWB);
    add("fetch_wait1", 1, T_R, 0, F0);
    add("fetch_wait2", 1, T_R, 0, F0);
    add("fetch_wait3", 1, T_R, 0, F0);
    add("fetch_done", 1, T_R, 1, F1);
    add("r_decode", 1, T_R, 1, DEC);
    add("r_exec", 1, T_R, 0, RE);
    add("r_wb", 1, T_R, 0, RW);
    add("andi_fetch", 1, T_ANDI, 1, F1);
    add("andi_decode", 1, T_ANDI, 1, DEC);
    add("andi_exec", 1, T_ANDI, 1, IE);
    add("andi_wb", 1, T_ANDI, 1, IW);
    add("bez_fetch", 1, T_BEZ, 1, F1);
    add("bez_decode", 1, T_BEZ, 1, DEC);
    add("bez_branch", 1, T_BEZ, 1, BR0);
    add("bgez_fetch", 1, T_BGEZ, 1, F1);
    add("bgez_decode", 1, T_BGEZ, 1, DEC);
    add("bgez_branch", 1, T_BGEZ, 1, BR1);
    add("jm_fetch", 1, T_JM, 1, F1);
    add("jm_decode", 1, T_JM, 1, DEC);
    add("jm_addr", 1, T_JM, 1, MA);
    add("jm_wait", 1, T_JM, 0, JM0);
    add("jm_done", 1, T_JM, 1, JM1);
    add("sw_fetch", 1, T_SW, 1, F1);
    add("sw_decode", 1, T_SW, 1, DEC);
    add("sw_addr", 1, T_SW, 1, MA);
    add("sw_wait", 1, T_SW, 0, STR);
    add("sw_done", 1, T_SW, 1, STR);
    add("j_fetch", 1, T_J, 1, F1);
    add("j_decode", 1, T_J, 1, DEC);
    add("j_jump", 1, T_J, 1, JP);
    add("ill_fetch", 1, T_BAD, 1, F1);
    add("ill_decode", 1, T_BAD, 1, DILL);
    add("ill_refetch", 1, T_BAD, 1, F1);
    add("rst_lw_decode", 1, T_LW, 1, DEC);
    add("rst_lw_addr", 1, T_LW, 1, MA);
    add("rst_lw_read", 1, T_LW, 0, MRD);
    add("rst_mid_read", 0, T_LW, 0, Z);
    add("rst_hold", 0, T_LW, 1, Z);
    add("rst_release", 1, T_LW, 0, F0);

    foreach (tbl[i]) apply(tbl[i].name, tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].exp);

    // Randomized instruction stream; the DUT is in FETCH at this point.
    plan.delete();
    cur_op = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (plan.size() == 0) begin
        case ($urandom_range(0, 9))
          0: cur_op = T_R;    1: cur_op = T_LW;   2: cur_op = T_SW;
          3: cur_op = T_ANDI; 4: cur_op = T_BEZ;  5: cur_op = T_BGEZ;
          6: cur_op = T_J;    7: cur_op = T_JM;
          default: cur_op = 6'($urandom);
        endcase
        build_plan(cur_op);
      end
      r        = ($urandom_range(0, 149) != 0);
      rdy      = ($urandom_range(0, 3) != 0);
      drive_op = (plan[0] == K_FETCH) ? 6'($urandom) : cur_op;
      e        = r ? expect_step(plan[0], rdy, cur_op) : Z;
      apply($sformatf("rand_cyc%0d_op%b", cyc, cur_op), r, drive_op, rdy, e);
      if (!r) plan.delete();
      else if (!(waits_on_memory(plan[0]) && !rdy)) void'(plan.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
